sdio_wbuf: RTL



---
 rtl/sdio_wbuf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sdio_wbuf.sv
// SDIO write-path ping-pong byte buffer and 1/4-bit DAT serializer (sd_clk domain).
// Optional underrun detection is enabled by defining SDIO_WBUF_UNDERRUN_EN.
module sdio_wbuf (
    input  logic       sd_clk,
    input  logic       rstn,
    input  logic       sd_rst,
    input  logic       buf_wr,
    input  logic [7:0] buf_wdata,
    output logic       buf_wr_rdy,
    output logic       buf0_full,
    output logic       buf1_full,
    input  logic       wide_bus,
    input  logic       tx_en,
    output logic [3:0] dat_out,
    output logic       dat_vld,
    output logic       byte_done,
    output logic       underrun
);

    logic [1:0] r_full;
    logic       r_wptr;
    logic       r_rptr;
    logic [7:0] r_slot0;
    logic [7:0] r_slot1;
    logic [7:0] r_sh;
    logic       r_sh_vld;
    logic       r_bw;
    logic [2:0] r_cnt;
    logic       r_byte_done;

    logic       w_wr;
    logic       w_beat;
    logic       w_last;
    logic       w_load;
    logic [7:0] w_rd_data;
    logic [1:0] w_full_nxt;

    assign w_wr      = buf_wr & ~r_full[r_wptr];
    assign w_beat    = tx_en & r_sh_vld;
    assign w_last    = w_beat & (r_cnt == 3'd1);
    assign w_load    = r_full[r_rptr] & (~r_sh_vld | w_last);
    assign w_rd_data = r_rptr ? r_slot1 : r_slot0;

    // A write needs an empty slot and a load needs a full one, so they never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr)
            w_full_nxt[r_wptr] = 1'b1;
        if (w_load)
            w_full_nxt[r_rptr] = 1'b0;
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            r_full      <= 2'b00;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_slot0     <= 8'h00;
            r_slot1     <= 8'h00;
            r_sh        <= 8'hFF;
            r_sh_vld    <= 1'b0;
            r_bw        <= 1'b0;
            r_cnt       <= 3'd0;
            r_byte_done <= 1'b0;
        end else if (sd_rst) begin
            r_full      <= 2'b00;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_slot0     <= 8'h00;
            r_slot1     <= 8'h00;
            r_sh        <= 8'hFF;
            r_sh_vld    <= 1'b0;
            r_bw        <= 1'b0;
            r_cnt       <= 3'd0;
            r_byte_done <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_byte_done <= w_last;
            if (w_wr) begin
                if (r_wptr)
                    r_slot1 <= buf_wdata;
                else
                    r_slot0 <= buf_wdata;
                r_wptr <= ~r_wptr;
            end
            if (w_load) begin
                r_sh     <= w_rd_data;
                r_rptr   <= ~r_rptr;
                r_bw     <= wide_bus;
                // 8 beats is encoded as 0: the 3-bit count wraps 0->7 on the first beat.
                r_cnt    <= wide_bus ? 3'd2 : 3'd0;
                r_sh_vld <= 1'b1;
            end else if (w_beat) begin
                r_sh  <= r_bw ? {r_sh[3:0], 4'hF} : {r_sh[6:0], 1'b1};
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1)
                    r_sh_vld <= 1'b0;
            end
        end
    end

`ifdef SDIO_WBUF_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn)
            r_underrun <= 1'b0;
        else if (sd_rst)
            r_underrun <= 1'b0;
        else if (tx_en & ~r_sh_vld)
            r_underrun <= 1'b1;
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

    assign buf_wr_rdy = ~r_full[r_wptr];
    assign buf0_full  = r_full[0];
    assign buf1_full  = r_full[1];
    assign dat_vld    = r_sh_vld;
    assign byte_done  = r_byte_done;
    // Shifter refills with ones, so an idle line reads 4'hF in either width.
    assign dat_out    = r_bw ? r_sh[7:4] : {3'b111, r_sh[7]};

endmodule
